video_timing_gen: RTL and testbench

Parametrised, runtime-programmable video timing and test-pattern generator for the Pano video output path. Runs in the pixel clock domain (`vo_clk`, sourced from the IDT synthesiser CLK1). It produces registered sync, blank and RGB outputs for `vo_*` pins. Timing is loaded from a shadow register and applied only at frame boundaries. It adds selectable sync polarity, four pattern modes, config validation and frame/line markers.

---
 rtl/video_timing_gen.sv | 185 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Programmable video timing and test-pattern generator in the pixel clock domain.
// Config goes to a shadow set on cfg_valid and swaps into the active set at the frame boundary.
module video_timing_gen #(
    parameter int          H_W        = 12,
    parameter int          V_W        = 12,
    parameter int unsigned H_ACTIVE_D = 1920,
    parameter int unsigned H_FP_D     = 88,
    parameter int unsigned H_SYNC_D   = 44,
    parameter int unsigned H_BP_D     = 148,
    parameter int unsigned V_ACTIVE_D = 1080,
    parameter int unsigned V_FP_D     = 4,
    parameter int unsigned V_SYNC_D   = 5,
    parameter int unsigned V_BP_D     = 36,
    parameter bit          H_POS_D    = 1'b1,
    parameter bit          V_POS_D    = 1'b1
) (
    input  logic           vo_clk,
    input  logic           vo_reset,
    input  logic           cfg_valid,
    input  logic [H_W-1:0] cfg_h_active,
    input  logic [H_W-1:0] cfg_h_fp,
    input  logic [H_W-1:0] cfg_h_sync,
    input  logic [H_W-1:0] cfg_h_bp,
    input  logic [V_W-1:0] cfg_v_active,
    input  logic [V_W-1:0] cfg_v_fp,
    input  logic [V_W-1:0] cfg_v_sync,
    input  logic [V_W-1:0] cfg_v_bp,
    input  logic           cfg_h_pos,
    input  logic           cfg_v_pos,
    input  logic [1:0]     pat_mode,
    input  logic [23:0]    pat_solid,
    output logic           cfg_pending,
    output logic           cfg_err,
    output logic           vo_hsync,
    output logic           vo_vsync,
    output logic           vo_blank_,
    output logic [7:0]     vo_r,
    output logic [7:0]     vo_g,
    output logic [7:0]     vo_b,
    output logic           vo_sof,
    output logic           vo_sol
);

    typedef struct packed {
        logic [H_W-1:0] ha, hfp, hs, hbp;
        logic [V_W-1:0] va, vfp, vs, vbp;
        logic           hpos, vpos;
    } timing_t;

    localparam timing_t DEF = '{
        ha: H_W'(H_ACTIVE_D), hfp: H_W'(H_FP_D), hs: H_W'(H_SYNC_D), hbp: H_W'(H_BP_D),
        va: V_W'(V_ACTIVE_D), vfp: V_W'(V_FP_D), vs: V_W'(V_SYNC_D), vbp: V_W'(V_BP_D),
        hpos: H_POS_D, vpos: V_POS_D};

    timing_t        act, pnd, cfg_in;
    logic           pend;
    logic [H_W-1:0] col;
    logic [V_W-1:0] line;
    logic [H_W+1:0] cfg_htot;
    logic [V_W+1:0] cfg_vtot;
    logic           cfg_ok, accept;
    logic [H_W-1:0] h_last;
    logic [V_W-1:0] v_last;
    logic           col_end, frame_end;
    logic [H_W-1:0] bar_w, bar_c;
    logic [2:0]     bar_i;
    logic [H_W+1:0] hs_start, hs_stop;
    logic [V_W+1:0] vs_start, vs_stop;
    logic           blank, hs_raw, vs_raw;
    logic [23:0]    pix;

    assign cfg_in = '{
        ha: cfg_h_active, hfp: cfg_h_fp, hs: cfg_h_sync, hbp: cfg_h_bp,
        va: cfg_v_active, vfp: cfg_v_fp, vs: cfg_v_sync, vbp: cfg_v_bp,
        hpos: cfg_h_pos, vpos: cfg_v_pos};

    // Totals are two bits wider so an oversize frame is caught rather than wrapped.
    assign cfg_htot = {2'b00, cfg_h_active} + {2'b00, cfg_h_fp} + {2'b00, cfg_h_sync} + {2'b00, cfg_h_bp};
    assign cfg_vtot = {2'b00, cfg_v_active} + {2'b00, cfg_v_fp} + {2'b00, cfg_v_sync} + {2'b00, cfg_v_bp};
    assign cfg_ok   = (cfg_h_active != '0) && (cfg_h_fp != '0) && (cfg_h_sync != '0) && (cfg_h_bp != '0) &&
                      (cfg_v_active != '0) && (cfg_v_fp != '0) && (cfg_v_sync != '0) && (cfg_v_bp != '0) &&
                      (cfg_htot[H_W+1:H_W] == 2'b00) && (cfg_vtot[V_W+1:V_W] == 2'b00);
    assign accept   = cfg_valid && cfg_ok;

    assign h_last    = act.ha + act.hfp + act.hs + act.hbp - H_W'(1);
    assign v_last    = act.va + act.vfp + act.vs + act.vbp - V_W'(1);
    assign col_end   = (col == h_last);
    assign frame_end = col_end && (line == v_last);
    assign cfg_pending = pend;

    always_ff @(posedge vo_clk or posedge vo_reset) begin
        if (vo_reset) begin
            act     <= DEF;
            pnd     <= DEF;
            pend    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_valid && !cfg_ok;
            if (accept)
                pnd <= cfg_in;
            // An accept landing on the boundary cycle bypasses the shadow set.
            if (frame_end && (pend || accept)) begin
                act  <= accept ? cfg_in : pnd;
                pend <= 1'b0;
            end else if (accept) begin
                pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge vo_clk or posedge vo_reset) begin
        if (vo_reset) begin
            col  <= '0;
            line <= '0;
        end else if (frame_end) begin
            col  <= '0;
            line <= '0;
        end else if (col_end) begin
            col  <= '0;
            line <= line + V_W'(1);
        end else begin
            col  <= col + H_W'(1);
        end
    end

    // Bar index tracks col / (ha>>3), clamped at 7, without a divider.
    assign bar_w = act.ha >> 3;

    always_ff @(posedge vo_clk or posedge vo_reset) begin
        if (vo_reset) begin
            bar_i <= '0;
            bar_c <= '0;
        end else if (col_end) begin
            bar_i <= '0;
            bar_c <= '0;
        end else if (bar_w != '0) begin
            if (bar_c == bar_w - H_W'(1)) begin
                bar_c <= '0;
                if (bar_i != 3'd7)
                    bar_i <= bar_i + 3'd1;
            end else begin
                bar_c <= bar_c + H_W'(1);
            end
        end
    end

    assign hs_start = {2'b00, act.ha} + {2'b00, act.hfp};
    assign hs_stop  = hs_start + {2'b00, act.hs};
    assign vs_start = {2'b00, act.va} + {2'b00, act.vfp};
    assign vs_stop  = vs_start + {2'b00, act.vs};
    assign hs_raw   = ({2'b00, col} >= hs_start) && ({2'b00, col} < hs_stop);
    assign vs_raw   = ({2'b00, line} >= vs_start) && ({2'b00, line} < vs_stop);
    assign blank    = (col >= act.ha) || (line >= act.va);

    always_comb begin
        pix = '0;
        case (pat_mode)
            2'd0:    pix = '0;
            2'd1:    pix = {8'hFF, line[4:0], 3'b000, col[4:0], 3'b000};
            2'd2:    pix = {{8{~bar_i[1]}}, {8{~bar_i[2]}}, {8{~bar_i[0]}}};
            default: pix = pat_solid;
        endcase
    end

    always_ff @(posedge vo_clk or posedge vo_reset) begin
        if (vo_reset) begin
            vo_hsync  <= ~H_POS_D;
            vo_vsync  <= ~V_POS_D;
            vo_blank_ <= 1'b0;
            vo_r      <= '0;
            vo_g      <= '0;
            vo_b      <= '0;
            vo_sof    <= 1'b0;
            vo_sol    <= 1'b0;
        end else begin
            vo_hsync           <= ~(hs_raw ^ act.hpos);
            vo_vsync           <= ~(vs_raw ^ act.vpos);
            vo_blank_          <= ~blank;
            {vo_r, vo_g, vo_b} <= blank ? 24'h0 : pix;
            vo_sof             <= (col == '0) && (line == '0);
            vo_sol             <= (col == '0) && (line < act.va);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: frame-position model checked every cycle, plus literal spot checks.
module tb_video_timing_gen;

    localparam int H_W = 12;
    localparam int V_W = 12;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp;
        bit hp, vp;
    } cfg_t;

    localparam cfg_t DEF   = '{12, 2, 2, 4, 6, 1, 1, 2, 1'b1, 1'b1};
    localparam cfg_t SMALL = '{8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1};
    localparam logic [30:0] RST_VEC = {4'b0000, 1'b0, 24'h0, 2'b00};

    logic           vo_clk = 1'b0;
    logic           vo_reset = 1'b1;
    logic           cfg_valid = 1'b0;
    logic [H_W-1:0] cfg_h_active = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
    logic [V_W-1:0] cfg_v_active = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
    logic           cfg_h_pos = 1'b0, cfg_v_pos = 1'b0;
    logic [1:0]     pat_mode = 2'd0;
    logic [23:0]    pat_solid = 24'h0;
    logic           cfg_pending, cfg_err, vo_hsync, vo_vsync, vo_blank_, vo_sof, vo_sol;
    logic [7:0]     vo_r, vo_g, vo_b;
    logic [30:0]    dut_vec;

    int checks = 0, passes = 0, nprint = 0, cyc = 0;

    video_timing_gen #(
        .H_W(H_W), .V_W(V_W),
        .H_ACTIVE_D(12), .H_FP_D(2), .H_SYNC_D(2), .H_BP_D(4),
        .V_ACTIVE_D(6), .V_FP_D(1), .V_SYNC_D(1), .V_BP_D(2),
        .H_POS_D(1'b1), .V_POS_D(1'b1)
    ) dut (
        .vo_clk(vo_clk), .vo_reset(vo_reset), .cfg_valid(cfg_valid),
        .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_h_pos(cfg_h_pos), .cfg_v_pos(cfg_v_pos), .pat_mode(pat_mode), .pat_solid(pat_solid),
        .cfg_pending(cfg_pending), .cfg_err(cfg_err), .vo_hsync(vo_hsync), .vo_vsync(vo_vsync),
        .vo_blank_(vo_blank_), .vo_r(vo_r), .vo_g(vo_g), .vo_b(vo_b), .vo_sof(vo_sof), .vo_sol(vo_sol)
    );

    assign dut_vec = {cfg_pending, cfg_err, vo_hsync, vo_vsync, vo_blank_, vo_r, vo_g, vo_b, vo_sof, vo_sol};

    always #5 vo_clk = ~vo_clk;

    function automatic bit cfg_ok(cfg_t c);
        return c.ha > 0 && c.hfp > 0 && c.hs > 0 && c.hbp > 0 && c.va > 0 && c.vfp > 0 &&
               c.vs > 0 && c.vbp > 0 && (c.ha + c.hfp + c.hs + c.hbp) < (1 << H_W) &&
               (c.va + c.vfp + c.vs + c.vbp) < (1 << V_W);
    endfunction

    // Outputs for frame position t: col/line come from division, bars from col / (ha/8).
    function automatic logic [28:0] frame_out(cfg_t a, int t, logic [1:0] pm, logic [23:0] ps);
        int htot = a.ha + a.hfp + a.hs + a.hbp;
        int col = t % htot;
        int line = t / htot;
        int w = a.ha / 8;
        int i = (w == 0) ? 0 : col / w;
        bit blank = (col >= a.ha) || (line >= a.va);
        bit hsr = (col >= a.ha + a.hfp) && (col < a.ha + a.hfp + a.hs);
        bit vsr = (line >= a.va + a.vfp) && (line < a.va + a.vfp + a.vs);
        logic [23:0] rgb;
        if (i > 7) i = 7;
        case (pm)
            2'd0: rgb = 24'h0;
            2'd1: rgb = {8'hFF, 8'((line % 32) * 8), 8'((col % 32) * 8)};
            2'd2: rgb = {((i & 2) != 0) ? 8'h00 : 8'hFF, ((i & 4) != 0) ? 8'h00 : 8'hFF,
                         ((i & 1) != 0) ? 8'h00 : 8'hFF};
            default: rgb = ps;
        endcase
        if (blank) rgb = 24'h0;
        return {hsr == a.hp, vsr == a.vp, !blank, rgb, col == 0 && line == 0, col == 0 && line < a.va};
    endfunction

    cfg_t        m_act = DEF, m_pnd = DEF;
    bit          m_pend = 1'b0, started = 1'b0;
    int          m_t = 0;
    logic [30:0] exp_vec = RST_VEC;

    always @(posedge vo_clk) begin
        cfg_t cur;
        bit   err;
        logic [28:0] o;
        cyc++;
        if (vo_reset) begin
            m_act = DEF; m_pnd = DEF; m_pend = 1'b0; m_t = 0; exp_vec = RST_VEC;
        end else begin
            cur = '{int'(cfg_h_active), int'(cfg_h_fp), int'(cfg_h_sync), int'(cfg_h_bp),
                    int'(cfg_v_active), int'(cfg_v_fp), int'(cfg_v_sync), int'(cfg_v_bp),
                    cfg_h_pos, cfg_v_pos};
            o = frame_out(m_act, m_t, pat_mode, pat_solid);
            err = cfg_valid && !cfg_ok(cur);
            if (cfg_valid && cfg_ok(cur)) begin m_pnd = cur; m_pend = 1'b1; end
            if (m_t == (m_act.ha + m_act.hfp + m_act.hs + m_act.hbp) *
                       (m_act.va + m_act.vfp + m_act.vs + m_act.vbp) - 1) begin
                if (m_pend) begin m_act = m_pnd; m_pend = 1'b0; end
                m_t = 0;
            end else begin
                m_t++;
            end
            exp_vec = {m_pend, err, o};
        end
        started = 1'b1;
    end

    always @(negedge vo_clk) begin
        logic [30:0] e;
        if (started) begin
            e = vo_reset ? RST_VEC : exp_vec;
            checks++;
            if (dut_vec === e) passes++;
            else if (nprint < 20) begin
                nprint++;
                $display("FAIL cycle_outputs @%0d: got %h, required %h", cyc, dut_vec, e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic set_cfg(input cfg_t c);
        cfg_h_active = H_W'(c.ha); cfg_h_fp = H_W'(c.hfp); cfg_h_sync = H_W'(c.hs); cfg_h_bp = H_W'(c.hbp);
        cfg_v_active = V_W'(c.va); cfg_v_fp = V_W'(c.vfp); cfg_v_sync = V_W'(c.vs); cfg_v_bp = V_W'(c.vbp);
        cfg_h_pos = c.hp; cfg_v_pos = c.vp;
    endtask

    task automatic drive_cfg(input cfg_t c);
        set_cfg(c);
        cfg_valid = 1'b1;
        @(posedge vo_clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_sof(output int at);
        bit got = 1'b0;
        at = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge vo_clk);
            if (vo_sof) begin got = 1'b1; at = cyc; break; end
        end
        if (!got) begin checks++; $display("FAIL sof_timeout: got no sof, required one within 3000"); end
    endtask

    task automatic wait_apply();
        bit got = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge vo_clk);
            if (!cfg_pending) begin got = 1'b1; break; end
        end
        if (!got) begin checks++; $display("FAIL apply_timeout: cfg_pending stuck, required 0"); end
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.ha = $urandom_range(1, 16); c.hfp = $urandom_range(1, 3);
        c.hs = $urandom_range(1, 3);  c.hbp = $urandom_range(1, 3);
        c.va = $urandom_range(1, 6);  c.vfp = $urandom_range(1, 2);
        c.vs = $urandom_range(1, 2);  c.vbp = $urandom_range(1, 2);
        c.hp = 1'($urandom); c.vp = 1'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
                0: c.ha = 0;
                1: c.hs = 0;
                2: c.vfp = 0;
                default: c.vbp = 0;
            endcase
        end
        return c;
    endfunction

    initial begin
        int   t0, t1, t2;
        cfg_t c;
        bit   hs_s[129], vs_s[129], bl_s[129], sof_s[129], sol_s[129];
        logic [23:0] rgb19;
        logic [15:0] hmask;
        logic [7:0]  vmask;
        int   nact, nsol, nxt;

        // Reset values, then first frame after release.
        repeat (3) @(negedge vo_clk);
        check("rst_vec", 32'(dut_vec), 32'h0);
        @(posedge vo_clk); #1; vo_reset = 1'b0;
        @(posedge vo_clk); @(negedge vo_clk);
        check("rel_sof", 32'(vo_sof), 32'd1);
        check("rel_blank_", 32'(vo_blank_), 32'd1);

        // Randomized configs, accept timing and patterns; mid-pending reset once.
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 250)) begin
                @(posedge vo_clk); #1;
                pat_mode = 2'($urandom); pat_solid = 24'($urandom);
            end
            drive_cfg(rand_cfg());
            if ($urandom_range(0, 3) == 0) drive_cfg(rand_cfg());
            if (it == 20) begin
                drive_cfg(SMALL);
                vo_reset = 1'b1;
                @(negedge vo_clk);
                check("midrst_vec", 32'(dut_vec), 32'h0);
                check("midrst_pending", 32'(cfg_pending), 32'd0);
                repeat (2) @(posedge vo_clk);
                #1; vo_reset = 1'b0;
                @(negedge vo_clk); @(negedge vo_clk);
                check("midrst_sof", 32'(vo_sof), 32'd1);
            end
        end

        // Small config: 16x8 frame, gradient.
        pat_mode = 2'd1;
        drive_cfg(SMALL);
        wait_apply();
        wait_sof(t0);
        for (int k = 0; k < 129; k++) begin
            if (k > 0) @(negedge vo_clk);
            hs_s[k] = vo_hsync; vs_s[k] = vo_vsync; bl_s[k] = vo_blank_;
            sof_s[k] = vo_sof; sol_s[k] = vo_sol;
            if (k == 19) rgb19 = {vo_r, vo_g, vo_b};
        end
        hmask = '0; vmask = '0; nact = 0; nsol = 0; nxt = -1;
        for (int k = 0; k < 16; k++) hmask[k] = hs_s[k];
        for (int l = 0; l < 8; l++) vmask[l] = vs_s[l * 16];
        for (int k = 0; k < 128; k++) begin nact += int'(bl_s[k]); nsol += int'(sol_s[k]); end
        for (int k = 128; k > 0; k--) if (sof_s[k]) nxt = k;
        check("small_hsync_cols", 32'(hmask), 32'h1C00);
        check("small_vsync_lines", 32'(vmask), 32'h60);
        check("small_active_px", 32'(nact), 32'd32);
        check("small_sol_count", 32'(nsol), 32'd4);
        check("small_period", 32'(nxt), 32'd128);
        check("small_gradient", 32'(rgb19), 32'hFF0818);

        // Deferred apply; the later accept wins.
        wait_sof(t0);
        repeat (32) @(negedge vo_clk);
        drive_cfg('{10, 1, 2, 3, 5, 1, 1, 2, 1'b1, 1'b1});
        @(negedge vo_clk);
        check("defer_pending", 32'(cfg_pending), 32'd1);
        drive_cfg('{16, 2, 2, 4, 4, 1, 1, 2, 1'b1, 1'b1});
        wait_sof(t1);
        check("defer_old_period", 32'(t1 - t0), 32'd128);
        check("defer_pending_clr", 32'(cfg_pending), 32'd0);
        wait_sof(t2);
        check("defer_new_period", 32'(t2 - t1), 32'd192);

        // Rejects: zero sync width, and h_total of exactly 4096.
        c = '{16, 2, 0, 4, 4, 1, 1, 2, 1'b1, 1'b1};
        drive_cfg(c);
        @(negedge vo_clk);
        check("rej0_err", 32'(cfg_err), 32'd1);
        check("rej0_pending", 32'(cfg_pending), 32'd0);
        @(negedge vo_clk);
        check("rej0_err_once", 32'(cfg_err), 32'd0);
        drive_cfg('{4000, 32, 32, 32, 4, 1, 1, 2, 1'b1, 1'b1});
        @(negedge vo_clk);
        check("rej4096_err", 32'(cfg_err), 32'd1);
        check("rej4096_pending", 32'(cfg_pending), 32'd0);
        wait_sof(t1);
        wait_sof(t2);
        check("rej_period", 32'(t2 - t1), 32'd192);

        // Colour bars with ha=64.
        pat_mode = 2'd2;
        drive_cfg('{64, 4, 4, 8, 3, 1, 1, 1, 1'b1, 1'b1});
        wait_apply();
        wait_sof(t0);
        check("bar_px0", 32'({vo_r, vo_g, vo_b}), 32'hFFFFFF);
        repeat (8) @(negedge vo_clk);
        check("bar_px8", 32'({vo_r, vo_g, vo_b}), 32'hFFFF00);
        repeat (48) @(negedge vo_clk);
        check("bar_px56", 32'({vo_r, vo_g, vo_b}), 32'h000000);
        check("bar_px56_active", 32'(vo_blank_), 32'd1);
        repeat (8) @(negedge vo_clk);
        check("bar_px64_blank", 32'({vo_blank_, vo_r, vo_g, vo_b}), 32'h0);

        // Negative polarity, then an accept exactly on the boundary cycle.
        c = SMALL; c.hp = 1'b0; c.vp = 1'b0;
        drive_cfg(c);
        wait_apply();
        wait_sof(t0);
        check("neg_hsync_idle", 32'(vo_hsync), 32'd1);
        check("neg_vsync_idle", 32'(vo_vsync), 32'd1);
        repeat (10) @(negedge vo_clk);
        check("neg_hsync_pulse", 32'(vo_hsync), 32'd0);
        wait_sof(t0);
        repeat (126) @(posedge vo_clk);
        #1;
        set_cfg(SMALL);
        cfg_valid = 1'b1;
        @(posedge vo_clk); #1;
        cfg_valid = 1'b0;
        @(negedge vo_clk);
        check("bnd_pending_a", 32'(cfg_pending), 32'd0);
        check("bnd_last_col", 32'(vo_sof), 32'd0);
        @(negedge vo_clk);
        check("bnd_pending_b", 32'(cfg_pending), 32'd0);
        check("bnd_sof", 32'(vo_sof), 32'd1);
        check("bnd_new_pol", 32'(vo_hsync), 32'd0);
        repeat (4) @(negedge vo_clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
